// File: rtl/riscv_pkg.sv
// Shared RV64 integer-datapath constants used by the register file and its users.
package riscv_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile.sv
// Integer register file: x1..x31 in flops, x0 hard-wired to zero, two combinational
// read ports (rs1/rs2) and one clocked write port (rd) with synchronous active-low reset.
module regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = riscv_pkg::NREGS,
    parameter int unsigned AW    = riscv_pkg::AW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   Ra,
    input  logic [AW-1:0]   Rb,
    input  logic [AW-1:0]   Rw,
    input  logic            WE,
    input  logic [XLEN-1:0] Din,
    output logic [XLEN-1:0] Da,
    output logic [XLEN-1:0] Db
);

    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [XLEN-1:0] w_rd   [0:NREGS-1];
    logic            w_wr_en;

    assign w_wr_en = WE && (Rw != AW'(REG_ZERO));

    // Reset wins over a same-edge write; writes to x0 never reach storage.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[Rw] <= Din;
        end
    end

    // Full-size read view with x0 as a constant, so the read muxes need no special case.
    assign w_rd[0] = '0;
    for (genvar g = 1; g < NREGS; g++) begin : g_rd
        assign w_rd[g] = r_regs[g];
    end

    assign Da = w_rd[Ra];
    assign Db = w_rd[Rb];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by randomized traffic
// checked against an array model of the architectural register state.
module tb_regfile;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  Ra, Rb, Rw;
    logic        WE;
    logic [63:0] Din;
    logic [63:0] Da, Db;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mdl [32];

    always #5 CLK = ~CLK;

    regfile dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .Ra    (Ra),
        .Rb    (Rb),
        .Rw    (Rw),
        .WE    (WE),
        .Din   (Din),
        .Da    (Da),
        .Db    (Db)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Clock edge plus architectural update of the model from the inputs held across it.
    task automatic tick();
        @(posedge CLK);
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (WE && Rw != 5'd0) begin
            mdl[Rw] = Din;
        end
        #1;
    endtask

    task automatic chk_model(input string tag_a, input string tag_b);
        #1;
        chk(tag_a, Da, mdl[Ra]);
        chk(tag_b, Db, mdl[Rb]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 'x;
        mdl[0] = '0;
        RST_N = 1'b1; WE = 1'b0; Ra = '0; Rb = '0; Rw = '0; Din = '0;
        @(negedge CLK);

        #1;
        chk("x0_before_reset", Da, 64'd0);

        // 1: reset, then sweep both read ports
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        for (int a = 0; a < 32; a++) begin
            Ra = 5'(a); Rb = 5'(31 - a);
            #1;
            chk("reset_sweep_Da", Da, 64'd0);
            chk("reset_sweep_Db", Db, 64'd0);
        end

        // 2: basic write, old value visible until the edge
        WE = 1'b1; Rw = 5'd1; Din = 64'd234; Ra = 5'd0; Rb = 5'd1;
        #1;
        chk("x1_pre_edge", Db, 64'd0);
        tick();
        WE = 1'b0;
        #1;
        chk("x0_read", Da, 64'd0);
        chk("x1_written", Db, 64'd234);

        // 3: second register
        WE = 1'b1; Rw = 5'd18; Din = 64'd672;
        tick();
        WE = 1'b0; Ra = 5'd18; Rb = 5'd1;
        #1;
        chk("x18_written", Da, 64'd672);
        chk("x1_kept", Db, 64'd234);

        // 4: x0 immunity
        WE = 1'b1; Rw = 5'd0; Din = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        WE = 1'b0; Ra = 5'd0; Rb = 5'd1;
        #1;
        chk("x0_immune", Da, 64'd0);
        chk("x0_wr_x1_kept", Db, 64'd234);
        Rb = 5'd18;
        #1;
        chk("x0_wr_x18_kept", Db, 64'd672);

        // 5: write disabled, dual read of same register
        WE = 1'b0; Rw = 5'd1; Din = 64'd999;
        tick();
        Ra = 5'd1; Rb = 5'd1;
        #1;
        chk("we0_dual_Da", Da, 64'd234);
        chk("we0_dual_Db", Db, 64'd234);

        // 6: reset priority, then full-width write
        RST_N = 1'b0; WE = 1'b1; Rw = 5'd31; Din = 64'h8000_0000_0000_0001;
        tick();
        RST_N = 1'b1; WE = 1'b0; Ra = 5'd31; Rb = 5'd1;
        #1;
        chk("rst_prio_x31", Da, 64'd0);
        chk("rst_clears_x1", Db, 64'd0);
        WE = 1'b1;
        tick();
        WE = 1'b0;
        #1;
        chk("x31_full_width", Da, 64'h8000_0000_0000_0001);

        // Randomized traffic, biased toward a few registers so rewrites and reads collide.
        for (int n = 0; n < 400; n++) begin
            RST_N = ($urandom_range(0, 59) != 0);
            WE    = 1'($urandom_range(0, 1));
            Rw    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            Din   = {$urandom(), $urandom()};
            Ra    = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            Rb    = ($urandom_range(0, 3) == 0) ? Rw : 5'($urandom_range(0, 31));
            chk_model("rand_pre_Da", "rand_pre_Db");
            tick();
            chk_model("rand_post_Da", "rand_post_Db");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
